// File: rtl/alp_nibble_seq.sv
// Nibble-serial sequencer for a single 4-bit ALP ALU slice: walks byte/word/long
// operands LSB nibble first, ripples carry from the slice's g/p and assembles result and flags.
module alp_nibble_seq #(
    parameter int MAX_NIB = 8
) (
    input  logic                   clk_h,
    input  logic                   reset_l,
    input  logic                   start_h,
    input  logic [3:0]             op_h,
    input  logic                   bcd_op_l,
    input  logic                   pass_a_h,
    input  logic [1:0]             len_h,
    input  logic [4*MAX_NIB-1:0]   a_h,
    input  logic [4*MAX_NIB-1:0]   b_h,
    input  logic                   cin_h,
    output logic [3:0]             alu_h,
    output logic                   alu_bcd_op_l,
    output logic                   alu_pass_a_h,
    output logic [3:0]             amux_h,
    output logic [3:0]             bmux_h,
    output logic                   carry_in_h,
    output logic                   pg_in_h,
    input  logic [3:0]             aluq_h,
    input  logic                   alu_g_h,
    input  logic                   alu_p_h,
    input  logic                   alu_v_h,
    output logic                   busy_h,
    output logic                   done_h,
    output logic [4*MAX_NIB-1:0]   result_h,
    output logic                   c_h,
    output logic                   v_h,
    output logic                   z_h,
    output logic                   n_h
);
    localparam int W  = 4 * MAX_NIB;
    localparam int IW = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  result;
    logic [3:0]    op;
    logic          bcd_l;
    logic          pass_a;
    logic [1:0]    len;
    logic          carry;
    logic          zacc;
    logic [IW-1:0] idx;
    logic [IW-1:0] last_idx;
    logic          carry_next;
    logic          nib_zero;
    logic          last;

    always_comb begin
        case (len)
            2'b00:   last_idx = IW'(1);
            2'b01:   last_idx = IW'(3);
            default: last_idx = IW'(MAX_NIB - 1);
        endcase
    end

    assign carry_next = alu_g_h | (alu_p_h & carry);
    assign nib_zero   = (aluq_h == 4'h0);
    assign last       = (idx == last_idx);

    // Slice is fed straight from registered state; idx rests at 0 outside RUN.
    assign alu_h        = op;
    assign alu_bcd_op_l = bcd_l;
    assign alu_pass_a_h = pass_a;
    assign amux_h       = a_reg[{idx, 2'b00} +: 4];
    assign bmux_h       = b_reg[{idx, 2'b00} +: 4];
    assign carry_in_h   = carry;
    assign pg_in_h      = 1'b0;

    assign busy_h   = (state == RUN);
    assign done_h   = (state == DONE);
    assign result_h = result;

    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            state  <= IDLE;
            idx    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            op     <= '0;
            bcd_l  <= 1'b0;
            pass_a <= 1'b0;
            len    <= '0;
            carry  <= 1'b0;
            zacc   <= 1'b0;
            result <= '0;
            c_h    <= 1'b0;
            v_h    <= 1'b0;
            z_h    <= 1'b0;
            n_h    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_h) begin
                        a_reg  <= a_h;
                        b_reg  <= b_h;
                        op     <= op_h;
                        bcd_l  <= bcd_op_l;
                        pass_a <= pass_a_h;
                        len    <= len_h;
                        carry  <= cin_h;
                        idx    <= '0;
                        zacc   <= 1'b1;
                        result <= '0;
                        c_h    <= 1'b0;
                        v_h    <= 1'b0;
                        z_h    <= 1'b0;
                        n_h    <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= aluq_h;
                    carry <= carry_next;
                    zacc  <= zacc & nib_zero;
                    if (last) begin
                        c_h   <= carry_next;
                        v_h   <= alu_v_h;
                        n_h   <= aluq_h[3];
                        z_h   <= zacc & nib_zero;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alp_nibble_seq.sv
// Bench for alp_nibble_seq: behavioural 4-bit slice in the loop, table vectors,
// randomized operations against a whole-word reference model, handshake and reset corners.
module tb_alp_nibble_seq;
    logic        clk = 1'b0;
    logic        reset_l;
    logic        start;
    logic [3:0]  op;
    logic        bcd_l;
    logic        pass_a;
    logic [1:0]  len;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [3:0]  alu_op;
    logic        alu_bcd_l;
    logic        alu_pass_a;
    logic [3:0]  amux;
    logic [3:0]  bmux;
    logic        carry_in;
    logic        pg_in;
    logic [3:0]  sl_q;
    logic        sl_g;
    logic        sl_p;
    logic        sl_v;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        c_f, v_f, z_f, n_f;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alp_nibble_seq #(.MAX_NIB(8)) dut (
        .clk_h(clk), .reset_l(reset_l), .start_h(start), .op_h(op),
        .bcd_op_l(bcd_l), .pass_a_h(pass_a), .len_h(len), .a_h(a), .b_h(b),
        .cin_h(cin), .alu_h(alu_op), .alu_bcd_op_l(alu_bcd_l),
        .alu_pass_a_h(alu_pass_a), .amux_h(amux), .bmux_h(bmux),
        .carry_in_h(carry_in), .pg_in_h(pg_in), .aluq_h(sl_q), .alu_g_h(sl_g),
        .alu_p_h(sl_p), .alu_v_h(sl_v), .busy_h(busy), .done_h(done),
        .result_h(result), .c_h(c_f), .v_h(v_f), .z_h(z_f), .n_h(n_f)
    );

    // Slice model: op 0 add (binary or BCD), op 1 or pass_a = pass A, other ops = A AND B.
    logic [4:0] sl_sum;
    logic [4:0] sl_t;
    always_comb begin
        sl_sum = {1'b0, amux} + {1'b0, bmux};
        sl_t   = 5'd0;
        sl_q   = 4'h0;
        sl_g   = 1'b0;
        sl_p   = 1'b0;
        sl_v   = 1'b0;
        if (alu_pass_a || alu_op == 4'd1) begin
            sl_q = amux;
        end else if (alu_op != 4'd0) begin
            sl_q = amux & bmux;
        end else if (!alu_bcd_l) begin
            sl_g = (sl_sum > 5'd9);
            sl_p = (sl_sum == 5'd9);
            sl_t = sl_sum + {4'd0, carry_in};
            if (sl_t > 5'd9) sl_t = sl_t + 5'd6;
            sl_q = sl_t[3:0];
        end else begin
            sl_g = sl_sum[4];
            sl_p = (sl_sum == 5'd15);
            sl_t = sl_sum + {4'd0, carry_in};
            sl_q = sl_t[3:0];
            sl_v = (amux[3] == bmux[3]) && (sl_q[3] != amux[3]);
        end
    end

    typedef struct {
        string       name;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic        bcd_l, pass_a;
        logic [1:0]  len;
        logic        cin;
        logic [31:0] er;
        logic        ec, ev, ez, en;
        int          ebusy;
    } vec_t;

    vec_t vecs[6];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    function automatic longint unsigned bcd2int(input logic [31:0] x, input int nd);
        longint unsigned r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + longint'(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint unsigned s, input int nd);
        logic [31:0] r = '0;
        longint unsigned t = s;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Whole-word reference: arithmetic on the selected length, no nibble loop.
    task automatic ref_model(input logic [31:0] ra, input logic [31:0] rb, input logic [3:0] rop,
                             input logic rbcd_l, input logic rpass, input logic [1:0] rlen,
                             input logic rcin, output logic [31:0] r, output logic c,
                             output logic v, output logic z, output logic n);
        int nb = (rlen == 2'b00) ? 8 : (rlen == 2'b01) ? 16 : 32;
        longint unsigned mask = (64'd1 << nb) - 1;
        longint unsigned ma = longint'(ra) & mask;
        longint unsigned mb = longint'(rb) & mask;
        longint unsigned s;
        longint unsigned lim;
        c = 1'b0;
        v = 1'b0;
        if (rpass || rop == 4'd1) begin
            r = 32'(ma);
        end else if (rop != 4'd0) begin
            r = 32'(ma & mb);
        end else if (!rbcd_l) begin
            lim = 1;
            for (int i = 0; i < nb / 4; i++) lim = lim * 10;
            s = bcd2int(ra, nb / 4) + bcd2int(rb, nb / 4) + longint'(rcin);
            c = (s >= lim);
            r = int2bcd(s % lim, nb / 4);
        end else begin
            s = ma + mb + longint'(rcin);
            r = 32'(s & mask);
            c = s[nb];
            v = (ra[nb-1] == rb[nb-1]) && (r[nb-1] != ra[nb-1]);
        end
        z = (r == 32'd0);
        n = r[nb-1];
    endtask

    // Issues one operation from IDLE, returns outputs seen in the done cycle.
    task automatic do_op(input vec_t t, output logic [31:0] r, output logic c, output logic v,
                         output logic z, output logic n, output int bcnt);
        bit seen = 0;
        a = t.a; b = t.b; op = t.op; bcd_l = t.bcd_l; pass_a = t.pass_a;
        len = t.len; cin = t.cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin seen = 1; break; end
            if (busy) bcnt++;
            @(posedge clk); #1;
        end
        chk1({t.name, " done_seen"}, seen, 1'b1);
        r = result; c = c_f; v = v_f; z = z_f; n = n_f;
        @(posedge clk); #1;
        chk1({t.name, " done_one_cycle"}, done, 1'b0);
    endtask

    function automatic vec_t mk(input string nm, input logic [31:0] va, input logic [31:0] vb,
                                input logic [3:0] vop, input logic vbcd, input logic vpass,
                                input logic [1:0] vlen, input logic vcin, input logic [31:0] er,
                                input logic ec, input logic ez, input logic en, input int eb);
        vec_t t;
        t.name = nm; t.a = va; t.b = vb; t.op = vop; t.bcd_l = vbcd; t.pass_a = vpass;
        t.len = vlen; t.cin = vcin; t.er = er; t.ec = ec; t.ev = 1'b0; t.ez = ez; t.en = en;
        t.ebusy = eb;
        return t;
    endfunction

    logic [31:0] gr, er;
    logic        gc, gv, gz, gn, ec, ev, ez, en;
    int          bc, dcnt, bcnt2;
    vec_t        rv;

    initial begin
        vecs[0] = mk("long_add",  32'hFFFFFFFF, 32'h00000001, 4'd0, 1'b1, 1'b0, 2'b10, 1'b0,
                     32'h00000000, 1'b1, 1'b1, 1'b0, 8);
        vecs[1] = mk("word_add",  32'h00001234, 32'h00000FFF, 4'd0, 1'b1, 1'b0, 2'b01, 1'b0,
                     32'h00002233, 1'b0, 1'b0, 1'b0, 4);
        vecs[2] = mk("bcd_45_38", 32'h00000045, 32'h00000038, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0,
                     32'h00000083, 1'b0, 1'b0, 1'b1, 2);
        vecs[3] = mk("bcd_99_01", 32'h00000099, 32'h00000001, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0,
                     32'h00000000, 1'b1, 1'b1, 1'b0, 2);
        vecs[4] = mk("byte_pass", 32'hFFFF0080, 32'h00000000, 4'd1, 1'b1, 1'b1, 2'b00, 1'b0,
                     32'h00000080, 1'b0, 1'b0, 1'b1, 2);
        vecs[5] = mk("len11_add", 32'h12345678, 32'h11111111, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0,
                     32'h23456789, 1'b0, 1'b0, 1'b0, 8);

        reset_l = 1'b0; start = 1'b0; op = '0; bcd_l = 1'b1; pass_a = 1'b0; len = '0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk32("rst result", result, 32'h0);
        chk1("rst c", c_f, 1'b0);
        chk1("rst z", z_f, 1'b0);
        chk1("rst n", n_f, 1'b0);
        chk32("rst amux", {28'd0, amux}, 32'h0);
        chk1("pg_in", pg_in, 1'b0);
        reset_l = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i], gr, gc, gv, gz, gn, bc);
            chk32({vecs[i].name, " result"}, gr, vecs[i].er);
            chk1({vecs[i].name, " c"}, gc, vecs[i].ec);
            chk1({vecs[i].name, " v"}, gv, vecs[i].ev);
            chk1({vecs[i].name, " z"}, gz, vecs[i].ez);
            chk1({vecs[i].name, " n"}, gn, vecs[i].en);
            chk32({vecs[i].name, " busy_cycles"}, 32'(bc), 32'(vecs[i].ebusy));
        end
        chk32("idle hold result", result, 32'h23456789);

        for (int it = 0; it < 40; it++) begin
            int kind = $urandom_range(0, 3);
            rv.name = "rand";
            rv.len = 2'($urandom_range(0, 3));
            rv.cin = 1'($urandom_range(0, 1));
            rv.a = $urandom; rv.b = $urandom;
            rv.op = 4'd0; rv.bcd_l = 1'b1; rv.pass_a = 1'b0;
            if (kind == 1) begin
                rv.bcd_l = 1'b0;
                for (int d = 0; d < 8; d++) begin
                    rv.a[4*d +: 4] = 4'($urandom_range(0, 9));
                    rv.b[4*d +: 4] = 4'($urandom_range(0, 9));
                end
            end else if (kind == 2) begin
                rv.pass_a = 1'($urandom_range(0, 1));
                rv.op = rv.pass_a ? 4'($urandom_range(2, 15)) : 4'd1;
            end else if (kind == 3) begin
                rv.op = 4'($urandom_range(2, 15));
            end
            ref_model(rv.a, rv.b, rv.op, rv.bcd_l, rv.pass_a, rv.len, rv.cin, er, ec, ev, ez, en);
            do_op(rv, gr, gc, gv, gz, gn, bc);
            chk32("rand result", gr, er);
            chk1("rand c", gc, ec);
            chk1("rand v", gv, ev);
            chk1("rand z", gz, ez);
            chk1("rand n", gn, en);
            chk32("rand busy_cycles", 32'(bc), (rv.len == 2'b00) ? 32'd2 : (rv.len == 2'b01) ? 32'd4 : 32'd8);
        end

        // start held high through RUN and DONE: one op, then re-accept only from IDLE
        a = 32'h11; b = 32'h22; op = 4'd0; bcd_l = 1'b1; pass_a = 1'b0; len = 2'b00; cin = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        dcnt = 0; bcnt2 = 0;
        for (int k = 0; k < 3; k++) begin
            if (done) dcnt++;
            if (busy) bcnt2++;
            @(posedge clk); #1;
        end
        chk32("hold done_count", 32'(dcnt), 32'd1);
        chk32("hold busy_cycles", 32'(bcnt2), 32'd2);
        chk1("hold idle busy", busy, 1'b0);
        chk1("hold idle done", done, 1'b0);
        @(posedge clk); #1;
        chk1("hold reaccept busy", busy, 1'b1);
        start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk32("hold second done_count", 32'(dcnt), 32'd1);
        chk32("hold second result", result, 32'h33);

        // reset while nibble 3 of a long op is being processed
        a = 32'h11111111; b = 32'h11111111; len = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk1("midop busy", busy, 1'b1);
        chk32("midop partial", result, 32'h00000222);
        reset_l = 1'b0;
        @(posedge clk); #1;
        reset_l = 1'b1;
        chk1("abort busy", busy, 1'b0);
        chk1("abort done", done, 1'b0);
        chk32("abort result", result, 32'h0);
        chk32("abort flags", {28'd0, c_f, v_f, z_f, n_f}, 32'h0);
        dcnt = 0; bcnt2 = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) dcnt++;
            if (busy) bcnt2++;
            @(posedge clk); #1;
        end
        chk32("abort no_done", 32'(dcnt), 32'd0);
        chk32("abort no_busy", 32'(bcnt2), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alp_nibble_seq.md
Name: alp_nibble_seq

Overview:
- Sequencer that drives one 4-bit ALP ALU slice nibble-serially to perform byte/word/longword operations (binary or BCD).
- Latches 32-bit operands on a start request, then presents one nibble pair per cycle to the slice, LSB nibble first.
- Ripples carry between nibbles from the slice's generate/propagate outputs and assembles the result plus condition codes.
- Sits between microcode control and a single alpalu instance, sharing that slice across all nibble positions.

Parameters:
- MAX_NIB, 8, nibbles in a longword; fixes operand/result width at 4*MAX_NIB bits.

Ports:
- clk_h  in  1  clock; all state updates on rising edge
- reset_l  in  1  synchronous, active-low reset
- start_h  in  1  request new operation; sampled only in IDLE
- op_h  in  4  ALU function, forwarded to slice alu_h
- bcd_op_l  in  1  low = BCD operation; forwarded to slice
- pass_a_h  in  1  pass-A mux control; forwarded to slice
- len_h  in  2  operation length: 00 byte (2 nibbles), 01 word (4), 10 long (8), 11 treated as long
- a_h  in  32  operand A
- b_h  in  32  operand B
- cin_h  in  1  carry into nibble 0
- alu_h  out  4  to slice: latched op
- alu_bcd_op_l  out  1  to slice: latched bcd_op_l
- alu_pass_a_h  out  1  to slice: latched pass_a_h
- amux_h  out  4  to slice: current A nibble
- bmux_h  out  4  to slice: current B nibble
- carry_in_h  out  1  to slice: running carry
- pg_in_h  out  1  to slice: driven 0 (no external group lookahead)
- aluq_h  in  4  from slice: result nibble
- alu_g_h  in  1  from slice: nibble generate
- alu_p_h  in  1  from slice: nibble propagate
- alu_v_h  in  1  from slice: overflow for current nibble
- busy_h  out  1  high while in RUN
- done_h  out  1  one-cycle completion pulse
- result_h  out  32  assembled result
- c_h  out  1  carry out of the last nibble
- v_h  out  1  overflow of the last nibble
- z_h  out  1  result zero over the selected length
- n_h  out  1  MSB of the selected length

Behaviour:
- Reset (reset_l low at an edge):
  - state = IDLE; nibble index = 0; latched operands/controls = 0.
  - Outputs: result_h = 0, c/v/z/n = 0, busy_h = 0, done_h = 0.
  - Reset takes priority over all other events, including mid-RUN: the operation is aborted and no done_h pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start_h = 1: latch a_h, b_h, op_h, bcd_op_l, pass_a_h, len_h, cin_h.
  - Set index = 0, carry = cin_h, clear result register, then go to RUN.
  - On start_h = 0: remain in IDLE.
- RUN (one cycle per nibble):
  - Slice inputs are driven combinationally from registered state: amux_h = A[4i+3:4i], bmux_h = B[4i+3:4i], carry_in_h = carry.
  - At each edge: result[4i+3:4i] <= aluq_h; carry <= alu_g_h | (alu_p_h & carry); index <= index + 1.
  - On the last nibble (i = L-1, where L = 2, 4 or 8):
    - c_h <= new carry; v_h <= alu_v_h; n_h <= aluq_h[3].
    - z_h <= (all captured nibbles 0, including this one).
    - Go to DONE.
  - start_h is ignored while in RUN.
- DONE:
  - done_h = 1 for exactly this one cycle; busy_h = 0; next state is IDLE.
  - start_h is ignored in DONE.
- Latency: start accepted at edge T → busy_h high for L cycles → done_h high in cycle T+L+1.
- Result bits above the selected length read 0.
- result_h and the flags hold their values until the next accepted start, which clears them.
- In IDLE and DONE the slice outputs are stable: amux_h/bmux_h show nibble 0 of the latched operands, carry_in_h = latched carry.
- BCD correction is the slice's job; the sequencer only chains carry from g/p.

Test Plan:
- Binary long add: a=0xFFFFFFFF, b=0x00000001, cin=0 → after 8 busy cycles, done pulse; result=0x00000000, c=1, z=1, n=0.
- Binary word add: a=0x00001234, b=0x00000FFF, len=01 → result=0x00002233, c=0, z=0; busy high exactly 4 cycles.
- BCD byte add (bcd_op_l=0, slice model decimal): a=0x45, b=0x38 → result=0x83, c=0; repeat with a=0x99, b=0x01 → result=0x00, c=1, z=1.
- Length/flags: len=00, a=0xFFFF0080, b=0 with op=pass A → result=0x00000080, n=1, upper bits 0; len=11 behaves as long, 8 busy cycles.
- Handshake: start held high through RUN and DONE → exactly one operation and one done pulse; second op accepted only on the IDLE cycle after DONE.
- Reset mid-op: reset_l low during nibble 3 of a long op → next cycle busy=0, result=0, flags 0, and no done pulse follows.
